// File: rtl/regop_pkg.sv
// regop_pkg -- shared definitions for the regop_file register/op unit.
//   OP_NOP..OP_SWAP : 3-bit operation codes
//   OPW             : op code width
//   CNTW            : width of the accepted-op counter
//   op_sets_cf()    : true for ops that update the carry/borrow flag
package regop_pkg;

  localparam int OPW  = 3;
  localparam int CNTW = 16;

  localparam logic [OPW-1:0] OP_NOP  = 3'b000;
  localparam logic [OPW-1:0] OP_INC  = 3'b001;
  localparam logic [OPW-1:0] OP_DEC  = 3'b010;
  localparam logic [OPW-1:0] OP_CLR  = 3'b011;
  localparam logic [OPW-1:0] OP_LOAD = 3'b100;
  localparam logic [OPW-1:0] OP_ADD  = 3'b101;
  localparam logic [OPW-1:0] OP_MOV  = 3'b110;
  localparam logic [OPW-1:0] OP_SWAP = 3'b111;

  function automatic logic op_sets_cf(input logic [OPW-1:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/regop_alu.sv
// regop_alu -- combinational result/carry generator for one regop_file op.
// Ports:
//   op     in  OPW  operation code
//   a      in  W    destination register value (Rd)
//   b      in  W    source register value (Rs)
//   din    in  W    immediate for LOAD
//   result out W    new value for Rd
//   carry  out 1    carry-out (INC/ADD) or borrow (DEC); 0 for other ops
// Build option: define REGOP_SAT_EN to clamp INC/ADD at all-ones and DEC at
// zero instead of wrapping. carry still reports the would-be carry/borrow.
module regop_alu
  import regop_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   result,
  output logic           carry
);

`ifdef REGOP_SAT_EN
  // Bit W of the extended sum is the carry: clamp to all-ones when set.
  function automatic logic [W-1:0] sat_hi(input logic [W:0] s);
    return s[W] ? '1 : s[W-1:0];
  endfunction

  // Bit W of the extended difference is the borrow: clamp to zero when set.
  function automatic logic [W-1:0] sat_lo(input logic [W:0] s);
    return s[W] ? '0 : s[W-1:0];
  endfunction
`endif

  logic [W:0] w_sum;

  always_comb begin
    w_sum  = '0;
    result = a;
    carry  = 1'b0;
    case (op)
      OP_INC: begin
        w_sum = {1'b0, a} + {{W{1'b0}}, 1'b1};
        carry = w_sum[W];
`ifdef REGOP_SAT_EN
        result = sat_hi(w_sum);
`else
        result = w_sum[W-1:0];
`endif
      end
      OP_DEC: begin
        // Extended subtraction sets bit W exactly when a == 0 (borrow).
        w_sum = {1'b0, a} - {{W{1'b0}}, 1'b1};
        carry = w_sum[W];
`ifdef REGOP_SAT_EN
        result = sat_lo(w_sum);
`else
        result = w_sum[W-1:0];
`endif
      end
      OP_CLR:  result = '0;
      OP_LOAD: result = din;
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        carry = w_sum[W];
`ifdef REGOP_SAT_EN
        result = sat_hi(w_sum);
`else
        result = w_sum[W-1:0];
`endif
      end
      OP_MOV:  result = b;
      OP_SWAP: result = b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/regop_file.sv
// regop_file -- N x W register file applying one op per clock to a selected
// destination register, optionally reading a source register.
// Ports:
//   clk      in  1     rising-edge clock
//   reset    in  1     asynchronous active-high reset, clears all state
//   op_valid in  1     op/dest/src/din sampled only when high
//   op       in  3     operation code (regop_pkg OP_*)
//   dest     in  IW    destination register index
//   src      in  IW    source register index
//   din      in  W     immediate for LOAD
//   r_flat   out N*W   register k at bits [k*W +: W]
//   cf       out 1     carry/borrow flag (updated by INC/DEC/ADD only)
//   op_cnt   out 16    count of executed ops, wraps
// Build option: REGOP_SAT_EN selects saturating arithmetic in regop_alu.
module regop_file
  import regop_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [OPW-1:0]    op,
  input  logic [IW-1:0]     dest,
  input  logic [IW-1:0]     src,
  input  logic [W-1:0]      din,
  output logic [N*W-1:0]    r_flat,
  output logic              cf,
  output logic [CNTW-1:0]   op_cnt
);

  logic [W-1:0]    r_regs [N];
  logic            r_cf;
  logic [CNTW-1:0] r_cnt;

  logic            w_idx_ok;
  logic            w_accept;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [W-1:0]    w_result;
  logic            w_carry;

  // Indices past N-1 are only reachable when N is not a power of two;
  // such ops are dropped entirely (no write, no count, cf holds).
  assign w_idx_ok = (int'(dest) < N) && (int'(src) < N);
  assign w_accept = op_valid && w_idx_ok;
  assign w_a      = w_idx_ok ? r_regs[dest] : '0;
  assign w_b      = w_idx_ok ? r_regs[src]  : '0;

  regop_alu #(.W(W)) u_alu (
    .op     (op),
    .a      (w_a),
    .b      (w_b),
    .din    (din),
    .result (w_result),
    .carry  (w_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) r_regs[k] <= '0;
      r_cf  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_regs[dest] <= w_result;
      // SWAP's second write uses the pre-edge Rd; with dest==src both
      // writes carry the same value so the register is unchanged.
      if (op == OP_SWAP) r_regs[src] <= w_a;
      if (op_sets_cf(op)) r_cf <= w_carry;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign r_flat[k*W +: W] = r_regs[k];
  end

  assign cf     = r_cf;
  assign op_cnt = r_cnt;

endmodule
